alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential issue/writeback controller that sits directly upstream of the combinational 8-bit ALU and also consumes its outputs. Holds a small register file, accepts one operation at a time via a valid/ready handshake, drives `A`/`B`/`ALUctr` from the registered operands, and captures `Result`/`Zero`/`Overflow` back into the register file and flag registers. The module replaces free-running testbench stimulus with a cycle-exact operand source.

## Interface
- `WIDTH`, default 8: datapath width; must match the ALU instance parameter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ld_valid` in 1: preload strobe; writes `ld_data` to `ld_rd`.
- `ld_rd` in 2: preload register index, 0..3.
- `ld_data` in WIDTH: preload value.
- `in_valid` in 1: operation request.
- `in_ready` out 1: controller can accept an operation this cycle.
- `in_op` in 3: ALU control code, passed through opaquely as `alu_ctr`.
- `in_rs` in 2: source register for the A operand.
- `in_rt` in 2: source register for the B operand.
- `in_rd` in 2: destination register for the result.
- `alu_a` out WIDTH: drives ALU `A`.
- `alu_b` out WIDTH: drives ALU `B`.
- `alu_ctr` out 3: drives ALU `ALUctr`.
- `alu_result` in WIDTH: from ALU `Result`.
- `alu_zero` in 1: from ALU `Zero`.
- `alu_overflow` in 1: from ALU `Overflow`.
- `wb_valid` out 1: one-cycle pulse when the result is written back.
- `wb_rd` out 2: destination register being written; valid with `wb_valid`.
- `wb_data` out WIDTH: value being written; valid with `wb_valid`.
- `flag_zero` out 1: `Zero` from the last completed operation.
- `flag_ovf` out 1: sticky overflow flag.
- `clr_flags` in 1: clears `flag_zero` and `flag_ovf`.

## Operation
- FSM states: IDLE, EXEC, WB.
  - IDLE → EXEC when `in_valid && in_ready`.
  - EXEC → WB unconditionally.
  - WB → IDLE unconditionally.
- `in_ready` = (state == IDLE) && !`ld_valid`. A preload takes priority over an issue in the same cycle; the issue must be held.
- On accept, the following are captured into operand registers, so later register-file writes do not disturb the in-flight operation:
  - `regs[in_rs]` → `alu_a`
  - `regs[in_rt]` → `alu_b`
  - `in_op` → `alu_ctr`
  - `in_rd` → pending destination
- `rs`/`rt`/`rd` may alias; operands are the values present at accept.
- In EXEC the ALU output is combinational from the held operands. At the end of EXEC, `alu_result` → `wb_data`, `alu_zero` → zero staging, and `alu_overflow` → ovf staging.
- In WB:
  - `wb_valid`=1.
  - `regs[wb_rd]` ← `wb_data`.
  - `flag_zero` ← staged zero.
  - `flag_ovf` ← `flag_ovf` | staged ovf.
- `ld_valid` is honoured in any state. If it targets the same register as a WB write in the same cycle, WB wins.
- `clr_flags` in the same cycle as a WB flag update: the WB values win; `flag_ovf` is set if the staged ovf is 1.
- The controller performs no arithmetic; width is fixed to WIDTH with no extension.

## Timing
- Reset (`rst`=1 at an edge):
  - state=IDLE; all registers = 0.
  - `alu_a`=`alu_b`=0, `alu_ctr`=3'b000.
  - `wb_valid`=0, `wb_rd`=0, `wb_data`=0.
  - `flag_zero`=0, `flag_ovf`=0.
  - `in_ready`=1 from the first cycle after reset.
- Reset mid-operation aborts the operation: no writeback and no flag update.
- Latency:
  - Accept at edge N.
  - `alu_*` valid during cycle N+1 (EXEC).
  - `wb_valid` high during cycle N+2.
  - `in_ready` high again in cycle N+3.
  - Throughput: one operation per 3 cycles.
- `in_ready` is a registered-state function combined with `ld_valid`; there is no combinational path from `in_valid`.

## Structure
- Shared package `alu_pkg` holds:
  - `ALU_W` default = 8
  - `REG_AW` = 2
  - state enum {IDLE, EXEC, WB}
- Sub-module `alu_regfile`: 4×WIDTH, two combinational read ports, one synchronous write port with a priority mux (WB over load), reset to 0.
- The ALU itself stays external and is connected at the level above.

## Test plan
- Reset then idle → all outputs 0 and `in_ready`=1 one cycle after `rst` drops.
- Preload r1=0x32 and r2=0x35, then issue op=3'b110, rs=1, rt=2, rd=3 → in EXEC, `alu_a`=0x32, `alu_b`=0x35, `alu_ctr`=3'b110. Two cycles after accept, `wb_valid`=1 with `wb_rd`=3 and `wb_data` equal to the ALU model result (0xFD for subtract); r3 reads 0xFD afterwards.
- Issue with ALU overflow=1, then a second op with overflow=0 → `flag_ovf` stays 1 until `clr_flags`. `clr_flags` in the same cycle as an overflow WB leaves `flag_ovf`=1.
- `ld_valid` and `in_valid` in the same IDLE cycle → `in_ready`=0 and the load is applied. The op is accepted the next cycle and uses the newly loaded value.
- Preload to rd during EXEC with a WB to the same rd → the register holds `wb_data`, not `ld_data`. In-flight operands are unchanged by a load to rs during EXEC.
- Assert `rst` during EXEC → no `wb_valid`, all registers 0, FSM in IDLE.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and sizing for the ALU issue/writeback controller.
package alu_pkg;
  localparam int ALU_W    = 8;
  localparam int REG_AW   = 2;
  localparam int NUM_REGS = 1 << REG_AW;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;
endpackage

// File: rtl/alu_regfile.sv
// 4-entry register file: two combinational read ports, writeback and preload
// write sources where writeback wins on an address collision.
module alu_regfile
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] ra_addr,
  output logic [WIDTH-1:0]  ra_data,
  input  logic [REG_AW-1:0] rb_addr,
  output logic [WIDTH-1:0]  rb_data,
  input  logic              wb_we,
  input  logic [REG_AW-1:0] wb_addr,
  input  logic [WIDTH-1:0]  wb_data,
  input  logic              ld_we,
  input  logic [REG_AW-1:0] ld_addr,
  input  logic [WIDTH-1:0]  ld_data
);
  logic [WIDTH-1:0] regs [NUM_REGS];

  assign ra_data = regs[ra_addr];
  assign rb_data = regs[rb_addr];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wb_we && wb_addr == REG_AW'(i))      regs[i] <= wb_data;
        else if (ld_we && ld_addr == REG_AW'(i)) regs[i] <= ld_data;
      end
    end
  end
endmodule

// File: rtl/alu_issue_ctrl.sv
// Issue/writeback controller feeding an external combinational ALU; one
// operation in flight, three cycles per operation (IDLE -> EXEC -> WB).
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_valid,
  input  logic [REG_AW-1:0] ld_rd,
  input  logic [WIDTH-1:0]  ld_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [REG_AW-1:0] in_rs,
  input  logic [REG_AW-1:0] in_rt,
  input  logic [REG_AW-1:0] in_rd,
  output logic [WIDTH-1:0]  alu_a,
  output logic [WIDTH-1:0]  alu_b,
  output logic [2:0]        alu_ctr,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic              alu_zero,
  input  logic              alu_overflow,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [WIDTH-1:0]  wb_data,
  output logic              flag_zero,
  output logic              flag_ovf,
  input  logic              clr_flags
);
  state_t           state;
  logic             zero_stage;
  logic             ovf_stage;
  logic [WIDTH-1:0] rs_data;
  logic [WIDTH-1:0] rt_data;

  // Preload owns the cycle, so an issue presented alongside it must be held.
  assign in_ready = (state == IDLE) && !ld_valid;

  alu_regfile #(.WIDTH(WIDTH)) u_rf (
    .clk     (clk),
    .rst     (rst),
    .ra_addr (in_rs),
    .ra_data (rs_data),
    .rb_addr (in_rt),
    .rb_data (rt_data),
    .wb_we   (wb_valid),
    .wb_addr (wb_rd),
    .wb_data (wb_data),
    .ld_we   (ld_valid),
    .ld_addr (ld_rd),
    .ld_data (ld_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctr    <= 3'b000;
      wb_valid   <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
      zero_stage <= 1'b0;
      ovf_stage  <= 1'b0;
      flag_zero  <= 1'b0;
      flag_ovf   <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            alu_a   <= rs_data;
            alu_b   <= rt_data;
            alu_ctr <= in_op;
            wb_rd   <= in_rd;
            state   <= EXEC;
          end
        end
        EXEC: begin
          wb_data    <= alu_result;
          zero_stage <= alu_zero;
          ovf_stage  <= alu_overflow;
          wb_valid   <= 1'b1;
          state      <= WB;
        end
        WB:      state <= IDLE;
        default: state <= IDLE;
      endcase

      // A writeback flag update overrides a coincident clear.
      if (wb_valid) begin
        flag_zero <= zero_stage;
        flag_ovf  <= flag_ovf | ovf_stage;
      end else if (clr_flags) begin
        flag_zero <= 1'b0;
        flag_ovf  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a small behavioural 8-bit ALU attached.
module tb_alu_issue_ctrl;
  logic       clk = 0;
  logic       rst = 1;
  logic       ld_valid = 0;
  logic [1:0] ld_rd = 0;
  logic [7:0] ld_data = 0;
  logic       in_valid = 0;
  logic       in_ready;
  logic [2:0] in_op = 0;
  logic [1:0] in_rs = 0, in_rt = 0, in_rd = 0;
  logic [7:0] alu_a, alu_b;
  logic [2:0] alu_ctr;
  logic [7:0] alu_result;
  logic       alu_zero, alu_overflow;
  logic       wb_valid;
  logic [1:0] wb_rd;
  logic [7:0] wb_data;
  logic       flag_zero, flag_ovf;
  logic       clr_flags = 0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // Stand-in ALU: 010 add, 110 subtract, 000 and, others or.
  always_comb begin
    alu_overflow = 1'b0;
    case (alu_ctr)
      3'b010: begin
        alu_result   = alu_a + alu_b;
        alu_overflow = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      3'b110: begin
        alu_result   = alu_a - alu_b;
        alu_overflow = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
      end
      3'b000:  alu_result = alu_a & alu_b;
      default: alu_result = alu_a | alu_b;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  alu_issue_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctr(alu_ctr),
    .alu_result(alu_result), .alu_zero(alu_zero), .alu_overflow(alu_overflow),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .flag_zero(flag_zero), .flag_ovf(flag_ovf), .clr_flags(clr_flags)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] r, input logic [7:0] d);
    ld_valid = 1; ld_rd = r; ld_data = d;
    cyc();
    ld_valid = 0;
  endtask

  // Returns one step after the accepting edge, i.e. during EXEC.
  task automatic issue(input logic [2:0] op, input logic [1:0] rs, input logic [1:0] rt,
                       input logic [1:0] rd);
    int n = 0;
    in_valid = 1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    while (!in_ready && n < 10) begin
      cyc();
      n++;
    end
    tests++;
    if (!in_ready) begin
      fails++;
      $display("FAIL issue_wait: in_ready=%0b after %0d cycles, required 1", in_ready, n);
    end
    cyc();
    in_valid = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    cyc(); cyc();
    rst = 0;
    cyc();
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_in_ready: got %0b want 1", in_ready); end
    tests++; if (alu_a !== 8'h00) begin fails++; $display("FAIL rst_alu_a: got %h want 00", alu_a); end
    tests++; if (alu_b !== 8'h00) begin fails++; $display("FAIL rst_alu_b: got %h want 00", alu_b); end
    tests++; if (alu_ctr !== 3'b000) begin fails++; $display("FAIL rst_alu_ctr: got %b want 000", alu_ctr); end
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL rst_wb_valid: got %0b want 0", wb_valid); end
    tests++; if (wb_rd !== 2'd0) begin fails++; $display("FAIL rst_wb_rd: got %0d want 0", wb_rd); end
    tests++; if (wb_data !== 8'h00) begin fails++; $display("FAIL rst_wb_data: got %h want 00", wb_data); end
    tests++; if (flag_zero !== 1'b0) begin fails++; $display("FAIL rst_flag_zero: got %0b want 0", flag_zero); end
    tests++; if (flag_ovf !== 1'b0) begin fails++; $display("FAIL rst_flag_ovf: got %0b want 0", flag_ovf); end
  endtask

  task automatic test_sub();
    load(2'd1, 8'h32);
    load(2'd2, 8'h35);
    issue(3'b110, 2'd1, 2'd2, 2'd3);
    tests++; if (alu_a !== 8'h32) begin fails++; $display("FAIL sub_alu_a: got %h want 32", alu_a); end
    tests++; if (alu_b !== 8'h35) begin fails++; $display("FAIL sub_alu_b: got %h want 35", alu_b); end
    tests++; if (alu_ctr !== 3'b110) begin fails++; $display("FAIL sub_alu_ctr: got %b want 110", alu_ctr); end
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL sub_wb_early: got %0b want 0", wb_valid); end
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL sub_busy: in_ready got %0b want 0", in_ready); end
    cyc();
    tests++; if (wb_valid !== 1'b1) begin fails++; $display("FAIL sub_wb_valid: got %0b want 1", wb_valid); end
    tests++; if (wb_rd !== 2'd3) begin fails++; $display("FAIL sub_wb_rd: got %0d want 3", wb_rd); end
    tests++; if (wb_data !== 8'hFD) begin fails++; $display("FAIL sub_wb_data: got %h want FD", wb_data); end
    cyc();
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL sub_wb_pulse: got %0b want 0", wb_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL sub_ready_again: got %0b want 1", in_ready); end
    tests++; if (dut.u_rf.regs[3] !== 8'hFD) begin fails++; $display("FAIL sub_r3: got %h want FD", dut.u_rf.regs[3]); end
    tests++; if (flag_ovf !== 1'b0) begin fails++; $display("FAIL sub_ovf: got %0b want 0", flag_ovf); end
  endtask

  task automatic test_flags();
    load(2'd0, 8'h7F);
    load(2'd1, 8'h01);
    issue(3'b010, 2'd0, 2'd1, 2'd2);
    cyc(); cyc();
    tests++; if (dut.u_rf.regs[2] !== 8'h80) begin fails++; $display("FAIL ovf_r2: got %h want 80", dut.u_rf.regs[2]); end
    tests++; if (flag_ovf !== 1'b1) begin fails++; $display("FAIL ovf_set: got %0b want 1", flag_ovf); end
    issue(3'b010, 2'd1, 2'd1, 2'd3);
    cyc(); cyc();
    tests++; if (dut.u_rf.regs[3] !== 8'h02) begin fails++; $display("FAIL ovf_r3: got %h want 02", dut.u_rf.regs[3]); end
    tests++; if (flag_ovf !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %0b want 1", flag_ovf); end
    issue(3'b110, 2'd1, 2'd1, 2'd3);
    cyc(); cyc();
    tests++; if (flag_zero !== 1'b1) begin fails++; $display("FAIL zero_set: got %0b want 1", flag_zero); end
    clr_flags = 1;
    cyc();
    clr_flags = 0;
    tests++; if (flag_ovf !== 1'b0) begin fails++; $display("FAIL clr_ovf: got %0b want 0", flag_ovf); end
    tests++; if (flag_zero !== 1'b0) begin fails++; $display("FAIL clr_zero: got %0b want 0", flag_zero); end
    issue(3'b010, 2'd0, 2'd1, 2'd2);
    cyc();
    clr_flags = 1;
    cyc();
    clr_flags = 0;
    tests++; if (flag_ovf !== 1'b1) begin fails++; $display("FAIL clr_vs_wb_ovf: got %0b want 1", flag_ovf); end
  endtask

  task automatic test_ld_priority();
    ld_valid = 1; ld_rd = 2'd1; ld_data = 8'h10;
    in_valid = 1; in_op = 3'b010; in_rs = 2'd1; in_rt = 2'd1; in_rd = 2'd0;
    #1;
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL ldprio_ready: got %0b want 0", in_ready); end
    cyc();
    ld_valid = 0;
    #1;
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL ldprio_ready2: got %0b want 1", in_ready); end
    tests++; if (dut.u_rf.regs[1] !== 8'h10) begin fails++; $display("FAIL ldprio_r1: got %h want 10", dut.u_rf.regs[1]); end
    cyc();
    in_valid = 0;
    tests++; if (alu_a !== 8'h10) begin fails++; $display("FAIL ldprio_alu_a: got %h want 10", alu_a); end
    tests++; if (alu_b !== 8'h10) begin fails++; $display("FAIL ldprio_alu_b: got %h want 10", alu_b); end
    cyc(); cyc();
    tests++; if (dut.u_rf.regs[0] !== 8'h20) begin fails++; $display("FAIL ldprio_r0: got %h want 20", dut.u_rf.regs[0]); end
  endtask

  task automatic test_wb_collision();
    issue(3'b010, 2'd1, 2'd1, 2'd2);
    ld_valid = 1; ld_rd = 2'd1; ld_data = 8'h55;
    cyc();
    tests++; if (alu_a !== 8'h10) begin fails++; $display("FAIL coll_operand: alu_a got %h want 10", alu_a); end
    tests++; if (wb_data !== 8'h20) begin fails++; $display("FAIL coll_wb_data: got %h want 20", wb_data); end
    ld_rd = 2'd2; ld_data = 8'hAA;
    cyc();
    ld_valid = 0;
    tests++; if (dut.u_rf.regs[2] !== 8'h20) begin fails++; $display("FAIL coll_r2: got %h want 20", dut.u_rf.regs[2]); end
    tests++; if (dut.u_rf.regs[1] !== 8'h55) begin fails++; $display("FAIL coll_r1: got %h want 55", dut.u_rf.regs[1]); end
  endtask

  task automatic test_reset_mid();
    issue(3'b010, 2'd1, 2'd0, 2'd3);
    rst = 1;
    cyc();
    rst = 0;
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL rmid_wb_valid: got %0b want 0", wb_valid); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rmid_idle: in_ready got %0b want 1", in_ready); end
    for (int i = 0; i < 4; i++) begin
      tests++;
      if (dut.u_rf.regs[i] !== 8'h00) begin
        fails++; $display("FAIL rmid_reg%0d: got %h want 00", i, dut.u_rf.regs[i]);
      end
    end
    cyc();
    tests++; if (wb_valid !== 1'b0) begin fails++; $display("FAIL rmid_no_wb: got %0b want 0", wb_valid); end
    tests++; if (flag_ovf !== 1'b0) begin fails++; $display("FAIL rmid_flag_ovf: got %0b want 0", flag_ovf); end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_flags();
    test_ld_priority();
    test_wb_collision();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
